// File: rtl/unified_mem_arbiter.sv
// Single memory array shared by an instruction fetch port and a load/store port.
// One grant per cycle, fixed READ_LATENCY response pipeline, fixed-priority or round-robin arbitration.
module unified_mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,   // legal range 1..4
  parameter int ARB_MODE     = 0    // 0: D over I, 1: round-robin
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [31:0]             i_addr,
  output logic                    i_rsp_valid,
  output logic [DATA_WIDTH-1:0]   i_rsp_data,
  output logic                    i_rsp_err,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_we,
  input  logic [31:0]             d_addr,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_rsp_valid,
  output logic [DATA_WIDTH-1:0]   d_rsp_data
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  typedef struct packed {
    logic                  valid;
    logic                  is_d;
    logic                  err;
    logic                  is_store;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  grant_e                last_grant;
  grant_e                last_grant_next;
  logic                  grant_i;
  logic                  grant_d;
  logic [ADDR_WIDTH-1:0] i_idx;
  logic [ADDR_WIDTH-1:0] d_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  i_misaligned;
  logic                  rd_en;
  stage_t                head;
  stage_t                tail;
  stage_t                pipe [READ_LATENCY];
  logic                  unused_addr_bits;

  // Upper address bits alias; D-port byte offset is dropped rather than flagged.
  assign i_idx            = i_addr[ADDR_WIDTH+1:2];
  assign d_idx            = d_addr[ADDR_WIDTH+1:2];
  assign i_misaligned     = |i_addr[1:0];
  assign unused_addr_bits = ^{i_addr[31:ADDR_WIDTH+2], d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  // Handshake: a request transfers in any cycle where its valid and ready are both 1;
  // ready is a combinational function of both valids, last_grant and reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (ARB_MODE == 0) begin
        grant_d = d_req_valid;
        grant_i = i_req_valid && !d_req_valid;
      end else if (i_req_valid && d_req_valid) begin
        grant_d = (last_grant == GRANT_I);
        grant_i = (last_grant == GRANT_D);
      end else begin
        grant_d = d_req_valid;
        grant_i = i_req_valid;
      end
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    last_grant_next = last_grant;
    if (grant_d) begin
      last_grant_next = GRANT_D;
    end else if (grant_i) begin
      last_grant_next = GRANT_I;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GRANT_I;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Byte-masked store at the grant edge; reset suppresses the grant, so no write then.
  always_ff @(posedge clk) begin
    if (grant_d && d_we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (d_be[b]) begin
          mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
        end
      end
    end
  end

  assign rd_idx = grant_d ? d_idx : i_idx;
  assign rd_en  = (grant_d && !d_we) || (grant_i && !i_misaligned);

  always_comb begin
    head          = '0;
    head.valid    = grant_i || grant_d;
    head.is_d     = grant_d;
    head.err      = grant_i && i_misaligned;
    head.is_store = grant_d && d_we;
  end

  // Stage 0 captures the array read at the grant edge; later stages only pad latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      pipe[0] <= head;
      if (rd_en) begin
        pipe[0].data <= mem[rd_idx];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  assign tail        = pipe[READ_LATENCY-1];
  assign i_rsp_valid = tail.valid && !tail.is_d;
  assign i_rsp_err   = i_rsp_valid && tail.err;
  assign i_rsp_data  = i_rsp_valid ? tail.data : '0;
  assign d_rsp_valid = tail.valid && tail.is_d;
  assign d_rsp_data  = (d_rsp_valid && !tail.is_store) ? tail.data : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (fixed/lat2, rr/lat4, rr/lat1) on shared stimulus,
// directed sequences, an arbitration vector table and a random phase checked against a queue model.
module tb_unified_mem_arbiter;

  localparam int NI = 3;

  logic        clk;
  logic        reset;
  logic        i_req_valid;
  logic [31:0] i_addr;
  logic        d_req_valid;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;

  logic        i_ready [NI];
  logic        i_rv    [NI];
  logic [31:0] i_rd    [NI];
  logic        i_re    [NI];
  logic        d_ready [NI];
  logic        d_rv    [NI];
  logic [31:0] d_rd    [NI];

  unified_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .ARB_MODE(0)) u_fp2 (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_ready[0]), .i_addr(i_addr),
    .i_rsp_valid(i_rv[0]), .i_rsp_data(i_rd[0]), .i_rsp_err(i_re[0]),
    .d_req_valid(d_req_valid), .d_req_ready(d_ready[0]), .d_we(d_we), .d_addr(d_addr),
    .d_be(d_be), .d_wdata(d_wdata), .d_rsp_valid(d_rv[0]), .d_rsp_data(d_rd[0])
  );

  unified_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(4), .ARB_MODE(1)) u_rr4 (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_ready[1]), .i_addr(i_addr),
    .i_rsp_valid(i_rv[1]), .i_rsp_data(i_rd[1]), .i_rsp_err(i_re[1]),
    .d_req_valid(d_req_valid), .d_req_ready(d_ready[1]), .d_we(d_we), .d_addr(d_addr),
    .d_be(d_be), .d_wdata(d_wdata), .d_rsp_valid(d_rv[1]), .d_rsp_data(d_rd[1])
  );

  unified_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .ARB_MODE(1)) u_rr1 (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_ready[2]), .i_addr(i_addr),
    .i_rsp_valid(i_rv[2]), .i_rsp_data(i_rd[2]), .i_rsp_err(i_re[2]),
    .d_req_valid(d_req_valid), .d_req_ready(d_ready[2]), .d_we(d_we), .d_addr(d_addr),
    .d_be(d_be), .d_wdata(d_wdata), .d_rsp_valid(d_rv[2]), .d_rsp_data(d_rd[2])
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          port_d;
    logic [31:0] data;
    bit          err;
  } rsp_t;

  typedef struct {
    bit iv;
    bit dv;
    bit fp_i;
    bit fp_d;
    bit rr_i;
    bit rr_d;
  } arb_vec_t;

  logic [31:0] mem_m [NI][16];
  bit          last_d [NI];
  rsp_t        exp_q [NI][$];
  int          cyc;
  int          errors;
  int          checks;
  logic [31:0] last_i_data [NI];
  bit          last_i_err  [NI];
  logic [31:0] last_d_data [NI];
  int          d_seen      [NI];
  int          d_seen_cyc  [NI];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int mode_of(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: check readies, advance the model at the edge, check responses at the negedge.
  task automatic step();
    bit   gi [NI];
    bit   gd [NI];
    rsp_t r;
    bit   e_iv;
    bit   e_dv;
    logic [31:0] e_data;
    bit   e_err;
    #1;
    for (int k = 0; k < NI; k++) begin
      gi[k] = 1'b0;
      gd[k] = 1'b0;
      if (!reset) begin
        if (mode_of(k) == 0) begin
          gd[k] = d_req_valid;
          gi[k] = i_req_valid && !d_req_valid;
        end else if (i_req_valid && d_req_valid) begin
          gd[k] = !last_d[k];
          gi[k] = last_d[k];
        end else begin
          gd[k] = d_req_valid;
          gi[k] = i_req_valid;
        end
      end
      chk($sformatf("i_req_ready[%0d]", k), {31'd0, i_ready[k]}, {31'd0, gi[k]});
      chk($sformatf("d_req_ready[%0d]", k), {31'd0, d_ready[k]}, {31'd0, gd[k]});
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        exp_q[k].delete();
        last_d[k] = 1'b0;
      end else begin
        if (gd[k]) begin
          last_d[k] = 1'b1;
          r.due = cyc + lat_of(k);
          r.port_d = 1'b1;
          r.err = 1'b0;
          if (d_we) begin
            for (int b = 0; b < 4; b++)
              if (d_be[b]) mem_m[k][d_addr[5:2]][8*b +: 8] = d_wdata[8*b +: 8];
            r.data = 32'h0;
          end else begin
            r.data = mem_m[k][d_addr[5:2]];
          end
          exp_q[k].push_back(r);
        end
        if (gi[k]) begin
          last_d[k] = 1'b0;
          r.due = cyc + lat_of(k);
          r.port_d = 1'b0;
          r.err = (i_addr[1:0] != 2'b00);
          r.data = r.err ? 32'h0 : mem_m[k][i_addr[5:2]];
          exp_q[k].push_back(r);
        end
      end
    end
    cyc++;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      e_iv = 1'b0;
      e_dv = 1'b0;
      e_data = 32'h0;
      e_err = 1'b0;
      if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
        r = exp_q[k].pop_front();
        e_iv = !r.port_d;
        e_dv = r.port_d;
        e_data = r.data;
        e_err = r.err;
      end
      chk($sformatf("i_rsp_valid[%0d]", k), {31'd0, i_rv[k]}, {31'd0, e_iv});
      chk($sformatf("d_rsp_valid[%0d]", k), {31'd0, d_rv[k]}, {31'd0, e_dv});
      if (e_iv) begin
        chk($sformatf("i_rsp_data[%0d]", k), i_rd[k], e_data);
        chk($sformatf("i_rsp_err[%0d]", k), {31'd0, i_re[k]}, {31'd0, e_err});
      end
      if (e_dv) chk($sformatf("d_rsp_data[%0d]", k), d_rd[k], e_data);
      if (i_rv[k]) begin
        last_i_data[k] = i_rd[k];
        last_i_err[k] = i_re[k];
      end
      if (d_rv[k]) begin
        last_d_data[k] = d_rd[k];
        d_seen[k]++;
        d_seen_cyc[k] = cyc;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic d_op(input bit we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata);
    i_req_valid = 1'b0;
    d_req_valid = 1'b1;
    d_we = we;
    d_addr = addr;
    d_be = be;
    d_wdata = wdata;
    step();
    d_req_valid = 1'b0;
  endtask

  task automatic i_op(input logic [31:0] addr);
    d_req_valid = 1'b0;
    i_req_valid = 1'b1;
    i_addr = addr;
    step();
    i_req_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  arb_vec_t tbl [9];
  int       g;

  initial begin
    tbl[0] = '{1, 1, 0, 1, 0, 1};
    tbl[1] = '{1, 1, 0, 1, 1, 0};
    tbl[2] = '{1, 1, 0, 1, 0, 1};
    tbl[3] = '{1, 0, 1, 0, 1, 0};
    tbl[4] = '{1, 0, 1, 0, 1, 0};
    tbl[5] = '{1, 1, 0, 1, 0, 1};
    tbl[6] = '{0, 1, 0, 1, 0, 1};
    tbl[7] = '{1, 1, 0, 1, 1, 0};
    tbl[8] = '{0, 0, 0, 0, 0, 0};

    errors = 0;
    checks = 0;
    cyc = 0;
    reset = 1'b1;
    i_req_valid = 1'b0;
    i_addr = 32'h0;
    d_req_valid = 1'b0;
    d_we = 1'b0;
    d_addr = 32'h0;
    d_be = 4'h0;
    d_wdata = 32'h0;
    for (int k = 0; k < NI; k++) begin
      last_d[k] = 1'b0;
      last_i_data[k] = 32'h0;
      last_i_err[k] = 1'b0;
      last_d_data[k] = 32'h0;
      d_seen[k] = 0;
      d_seen_cyc[k] = 0;
    end

    @(negedge clk);
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    step();
    step();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("reset i_rsp_data[%0d]", k), i_rd[k], 32'h0);
      chk($sformatf("reset i_rsp_err[%0d]", k), {31'd0, i_re[k]}, 32'h0);
      chk($sformatf("reset d_rsp_data[%0d]", k), d_rd[k], 32'h0);
    end
    reset = 1'b0;
    idle(1);

    // Fill every word so nothing ever reads uninitialised storage.
    for (int w = 0; w < 16; w++) d_op(1'b1, 32'(w * 4), 4'hF, $urandom);
    idle(5);

    // Fetch of a preloaded word.
    d_op(1'b1, 32'h14, 4'hF, 32'h11223344);
    last_i_data[0] = 32'h0;
    i_op(32'h14);
    idle(5);
    chk("fetch word5", last_i_data[0], 32'h11223344);

    // Partial store followed immediately by a load of the same word.
    d_op(1'b1, 32'h14, 4'b0010, 32'h0000AB00);
    d_op(1'b0, 32'h14, 4'h0, 32'h0);
    idle(5);
    chk("load after byte store", last_d_data[0], 32'h1122AB44);

    // Misaligned fetch, then the word must be unchanged.
    last_i_err[0] = 1'b0;
    i_op(32'h16);
    idle(5);
    chk("misaligned err", {31'd0, last_i_err[0]}, 32'h1);
    chk("misaligned data", last_i_data[0], 32'h0);
    i_op(32'h14);
    idle(5);
    chk("word5 unchanged", last_i_data[0], 32'h1122AB44);

    // Aliasing: 0x40 maps onto word 0 with a 16-word array.
    d_op(1'b1, 32'h40, 4'hF, 32'hDEADBEEF);
    d_op(1'b0, 32'h00, 4'h0, 32'h0);
    idle(5);
    chk("alias load", last_d_data[2], 32'hDEADBEEF);

    // Arbitration vectors, starting from a fresh last_grant.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    i_addr = 32'h0;
    d_we = 1'b0;
    d_addr = 32'h8;
    for (int v = 0; v < 9; v++) begin
      i_req_valid = tbl[v].iv;
      d_req_valid = tbl[v].dv;
      #1;
      chk($sformatf("tbl%0d fp i_ready", v), {31'd0, i_ready[0]}, {31'd0, tbl[v].fp_i});
      chk($sformatf("tbl%0d fp d_ready", v), {31'd0, d_ready[0]}, {31'd0, tbl[v].fp_d});
      chk($sformatf("tbl%0d rr i_ready", v), {31'd0, i_ready[1]}, {31'd0, tbl[v].rr_i});
      chk($sformatf("tbl%0d rr d_ready", v), {31'd0, d_ready[1]}, {31'd0, tbl[v].rr_d});
      chk($sformatf("tbl%0d rr1 d_ready", v), {31'd0, d_ready[2]}, {31'd0, tbl[v].rr_d});
      step();
    end
    idle(5);

    // Reset with three loads in flight on the latency-4 instance.
    idle(1);
    d_seen[1] = 0;
    d_op(1'b0, 32'h0, 4'h0, 32'h0);
    d_op(1'b0, 32'h4, 4'h0, 32'h0);
    d_op(1'b0, 32'h8, 4'h0, 32'h0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(6);
    chk("flushed responses", d_seen[1], 0);
    g = cyc;
    d_op(1'b0, 32'h14, 4'h0, 32'h0);
    idle(6);
    chk("post-reset load count", d_seen[1], 1);
    chk("post-reset load latency", d_seen_cyc[1] - g, 4);
    chk("post-reset load data", last_d_data[1], 32'h1122AB44);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      i_req_valid = $urandom_range(0, 1);
      i_addr = $urandom;
      if ($urandom_range(0, 3) != 0) i_addr[1:0] = 2'b00;
      d_req_valid = $urandom_range(0, 1);
      d_we = $urandom_range(0, 1);
      d_addr = $urandom;
      d_be = 4'($urandom_range(0, 15));
      d_wdata = $urandom;
      step();
    end
    reset = 1'b0;
    idle(6);
    for (int k = 0; k < NI; k++) chk($sformatf("drained[%0d]", k), exp_q[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
